// File: rtl/sme_pkg.sv
// Shared types and GF(2^8) helpers for the SME word-wide AES unit.
package sme_pkg;

  typedef enum logic [2:0] {
    OpAeses, OpAesesm, OpAesds, OpAesdsm, OpSubw, OpIsubw, OpAesesmw, OpAesdsmw
  } op_e;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  function automatic int unsigned rmax(input int unsigned s);
    return s + s * (s - 1) / 2;
  endfunction

  // Bit i of bits corresponds to op_e'(i); the highest set bit wins.
  function automatic op_e op_prio(input logic [7:0] bits);
    op_e o;
    o = OpAeses;
    for (int i = 0; i < 8; i++) begin
      if (bits[i]) o = op_e'(3'(i));
    end
    return o;
  endfunction

  function automatic logic op_is_word(input op_e o);
    logic [2:0] v;
    v = o;
    return v[2];
  endfunction

  function automatic logic op_is_dec(input op_e o);
    return o inside {OpAesds, OpAesdsm, OpIsubw, OpAesdsmw};
  endfunction

  function automatic logic [7:0] xtime2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] xtimen(input logic [7:0] b, input logic [7:0] n);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h00;
    p = b;
    for (int i = 0; i < 8; i++) begin
      if (n[i]) r = r ^ p;
      p = xtime2(p);
    end
    return r;
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a3, a2, a1, a0} = w;
    return {xtimen(a0, 8'd3) ^ a1 ^ a2 ^ xtime2(a3),
            a0 ^ a1 ^ xtime2(a2) ^ xtimen(a3, 8'd3),
            a0 ^ xtime2(a1) ^ xtimen(a2, 8'd3) ^ a3,
            xtime2(a0) ^ xtimen(a1, 8'd3) ^ a2 ^ a3};
  endfunction

  function automatic logic [31:0] invmixcol(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a3, a2, a1, a0} = w;
    return {xtimen(a0, 8'd11) ^ xtimen(a1, 8'd13) ^ xtimen(a2, 8'd9) ^ xtimen(a3, 8'd14),
            xtimen(a0, 8'd13) ^ xtimen(a1, 8'd9) ^ xtimen(a2, 8'd14) ^ xtimen(a3, 8'd11),
            xtimen(a0, 8'd9) ^ xtimen(a1, 8'd14) ^ xtimen(a2, 8'd11) ^ xtimen(a3, 8'd13),
            xtimen(a0, 8'd14) ^ xtimen(a1, 8'd11) ^ xtimen(a2, 8'd13) ^ xtimen(a3, 8'd9)};
  endfunction

endpackage

// File: rtl/sme_aes_word_if.sv
// Request/response bundle between SME share-register read and the AES word unit.
interface sme_aes_word_if
  import sme_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned SMAX  = 3,
  parameter int unsigned NLANE = 1,
  parameter int unsigned RMAX  = rmax(SMAX)
) ();
  logic [3:0]                         smectl_d;
  logic [NLANE*RMAX-1:0][XLEN-1:0]    rng;
  logic                               flush;
  logic                               valid;
  logic                               ready;
  logic                               op_aeses, op_aesesm, op_aesds, op_aesdsm;
  logic                               op_subw, op_isubw, op_aesesmw, op_aesdsmw;
  logic [1:0]                         bs;
  logic [SMAX-1:0][XLEN-1:0]          rs1;
  logic [SMAX-1:0][XLEN-1:0]          rs2;
  logic [SMAX-1:0][XLEN-1:0]          rd;

  modport master (
    output smectl_d, rng, flush, valid, bs, rs1, rs2,
    output op_aeses, op_aesesm, op_aesds, op_aesdsm,
    output op_subw, op_isubw, op_aesesmw, op_aesdsmw,
    input  ready, rd
  );

  modport slave (
    input  smectl_d, rng, flush, valid, bs, rs1, rs2,
    input  op_aeses, op_aesesm, op_aesds, op_aesdsm,
    input  op_subw, op_isubw, op_aesesmw, op_aesdsmw,
    output ready, rd
  );
endinterface

// File: rtl/sme_aes_mixcol.sv
// Per-share linear result function f() applied to one 32-bit accumulator share.
module sme_aes_mixcol
  import sme_pkg::*;
(
  input  op_e         op,
  input  logic [1:0]  bs,
  input  logic [31:0] acc,
  output logic [31:0] res
);
  logic [7:0]  s;
  logic [31:0] col;
  logic [63:0] rot;

  always_comb begin
    s   = acc[{bs, 3'b000} +: 8];
    col = acc;
    unique case (op)
      OpAeses, OpAesds:   col = {24'h0, s};
      OpAesesm:           col = mixcol({24'h0, s});
      OpAesdsm:           col = invmixcol({24'h0, s});
      OpSubw, OpIsubw:    col = acc;
      OpAesesmw:          col = mixcol(acc);
      OpAesdsmw:          col = invmixcol(acc);
      default:            col = acc;
    endcase
    rot = {col, col} << {bs, 3'b000};
    res = op_is_word(op) ? col : rot[63:32];
  end
endmodule

// File: rtl/sme_aes_sbox.sv
// Share-domain AES sbox lane: fixed SBOX_LAT latency, fresh output sharing from rng.
module sme_aes_sbox
  import sme_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned SMAX     = 3,
  parameter int unsigned RMAX     = rmax(SMAX),
  parameter int unsigned SBOX_LAT = 3
) (
  input  logic                      g_clk,
  input  logic                      g_reset,
  input  logic                      en,
  input  logic                      inv,
  input  logic [SMAX-1:0]           shm,
  input  logic [SMAX-1:0][7:0]      din,
  input  logic [RMAX-1:0][XLEN-1:0] rng,
  output logic [SMAX-1:0][7:0]      dout
);
  localparam int unsigned M = (SMAX > 1) ? SMAX - 1 : 1;

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq, r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = xtimen(sq, sq);
      r  = xtimen(r, sq);
    end
    return r;
  endfunction

  logic [7:0]           x, y, acc0, r;
  logic [7:0]           rmix [SMAX];
  logic [SMAX-1:0][7:0] q;

  // Reference lane: recombines the input, then reshares with every rng word folded in.
  always_comb begin
    x = 8'h00;
    for (int s = 0; s < SMAX; s++) x = x ^ din[s];
    if (inv) begin
      y = gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    end else begin
      acc0 = gf_inv(x);
      y = acc0 ^ rotl8(acc0, 1) ^ rotl8(acc0, 2) ^ rotl8(acc0, 3) ^ rotl8(acc0, 4) ^ 8'h63;
    end
    for (int s = 0; s < SMAX; s++) rmix[s] = 8'h00;
    if (SMAX > 1) begin
      for (int j = 0; j < RMAX; j++) begin
        for (int b = 0; b < XLEN / 8; b++) begin
          rmix[1 + j % M] = rmix[1 + j % M] ^ rng[j][8*b +: 8];
        end
      end
    end
    acc0 = y;
    q    = '0;
    for (int s = 1; s < SMAX; s++) begin
      r    = shm[s] ? rmix[s] : 8'h00;
      q[s] = r;
      acc0 = acc0 ^ r;
    end
    q[0] = shm[0] ? acc0 : 8'h00;
  end

  if (SBOX_LAT < 2) begin : g_comb
    assign dout = q;
  end else begin : g_pipe
    logic [SMAX-1:0][7:0] stage_q [SBOX_LAT-1];
    always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
        for (int i = 0; i < SBOX_LAT - 1; i++) stage_q[i] <= '0;
      end else if (en) begin
        stage_q[0] <= q;
        for (int i = 1; i < SBOX_LAT - 1; i++) stage_q[i] <= stage_q[i-1];
      end
    end
    assign dout = stage_q[SBOX_LAT-2];
  end
endmodule

// File: rtl/sme_aes_word.sv
// Multi-cycle masked AES round-function unit: byte ops plus full-word SubWord/MixColumn ops.
module sme_aes_word
  import sme_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned SMAX     = 3,
  parameter int unsigned NLANE    = 1,
  parameter int unsigned SBOX_LAT = 3,
  parameter int unsigned RMAX     = rmax(SMAX)
) (
  input  logic          g_clk,
  input  logic          g_reset,
  output logic          g_clk_req,
  sme_aes_word_if.slave bus
);
  localparam int unsigned NPASS = 4 / NLANE;
  localparam int unsigned CW    = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;

  state_e                          state_q;
  op_e                             op_q, op_new;
  logic [1:0]                      pass_q, bs_q;
  logic [CW-1:0]                   cyc_q;
  logic [SMAX-1:0]                 shm_q, shm_new;
  logic [SMAX-1:0][XLEN-1:0]       rs1_q, rs2_q, acc_q, rd_q, acc_nxt, res;
  logic [SMAX-1:0][XLEN-1:0]       rs1_m, rs2_m;
  logic                            ready_q;
  logic [7:0]                      op_bits;
  logic [3:0]                      nsh;
  logic                            accept, abort, word_op, last_cyc, last_pass;
  logic [NLANE-1:0]                sb_en;
  logic [NLANE-1:0][1:0]           sb_idx;
  logic [NLANE-1:0][SMAX-1:0][7:0] sb_din, sb_dout;

  assign op_bits = {bus.op_aesdsmw, bus.op_aesesmw, bus.op_isubw, bus.op_subw,
                    bus.op_aesdsm, bus.op_aesds, bus.op_aesesm, bus.op_aeses};
  assign op_new  = op_prio(op_bits);
  assign accept  = (state_q == StIdle) && bus.valid && !bus.flush && (|op_bits);
  assign abort   = bus.flush || ((state_q == StRun) && !bus.valid);
  assign nsh     = (bus.smectl_d == 4'd0 || bus.smectl_d > 4'(SMAX)) ? 4'(SMAX) : bus.smectl_d;

  assign word_op   = op_is_word(op_q);
  assign last_cyc  = (cyc_q == CW'(SBOX_LAT - 1));
  assign last_pass = word_op ? (pass_q == 2'(NPASS - 1)) : 1'b1;

  always_comb begin
    for (int s = 0; s < SMAX; s++) begin
      shm_new[s] = (4'(s) < nsh);
      rs1_m[s]   = shm_new[s] ? bus.rs1[s] : '0;
      rs2_m[s]   = shm_new[s] ? bus.rs2[s] : '0;
    end
  end

  // Lane l of pass p handles byte p*NLANE+l; byte ops run lane 0 only on byte bs.
  always_comb begin
    acc_nxt = acc_q;
    for (int l = 0; l < NLANE; l++) begin
      sb_idx[l] = word_op ? 2'(int'(pass_q) * int'(NLANE) + l) : bs_q;
      sb_en[l]  = (state_q == StRun) && (word_op || l == 0);
      for (int s = 0; s < SMAX; s++) begin
        sb_din[l][s] = rs2_q[s][{sb_idx[l], 3'b000} +: 8];
        if (last_cyc && sb_en[l]) acc_nxt[s][{sb_idx[l], 3'b000} +: 8] = sb_dout[l][s];
      end
    end
  end

  for (genvar l = 0; l < NLANE; l++) begin : g_lane
    sme_aes_sbox #(
      .XLEN(XLEN), .SMAX(SMAX), .RMAX(RMAX), .SBOX_LAT(SBOX_LAT)
    ) u_sbox (
      .g_clk   (g_clk),
      .g_reset (g_reset),
      .en      (sb_en[l]),
      .inv     (op_is_dec(op_q)),
      .shm     (shm_q),
      .din     (sb_din[l]),
      .rng     (bus.rng[l*RMAX +: RMAX]),
      .dout    (sb_dout[l])
    );
  end

  for (genvar s = 0; s < SMAX; s++) begin : g_share
    sme_aes_mixcol u_mixcol (
      .op  (op_q),
      .bs  (bs_q),
      .acc (acc_nxt[s]),
      .res (res[s])
    );
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q <= StIdle;
      pass_q  <= '0;
      cyc_q   <= '0;
      op_q    <= OpAeses;
      bs_q    <= '0;
      shm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      acc_q   <= '0;
      rd_q    <= '0;
      ready_q <= 1'b0;
    end else if (abort) begin
      state_q <= StIdle;
      pass_q  <= '0;
      cyc_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StRun;
            op_q    <= op_new;
            bs_q    <= bus.bs;
            shm_q   <= shm_new;
            rs1_q   <= rs1_m;
            rs2_q   <= rs2_m;
            acc_q   <= '0;
            pass_q  <= '0;
            cyc_q   <= '0;
          end
        end
        StRun: begin
          if (last_cyc) begin
            acc_q <= acc_nxt;
            cyc_q <= '0;
            if (last_pass) begin
              state_q <= StDone;
              rd_q    <= res ^ rs1_q;
              ready_q <= 1'b1;
            end else begin
              pass_q <= pass_q + 2'd1;
            end
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.rd    = rd_q;
  assign g_clk_req = (state_q != StIdle) || bus.valid;
endmodule

// File: tb/tb_sme_aes_word.sv
// Directed bench for sme_aes_word: vector table plus flush and async-reset sequences.
module tb_sme_aes_word;
  localparam int unsigned XLEN = 32, SMAX = 3, NLANE = 1, SBOX_LAT = 3, RMAX = 6;

  logic g_clk = 1'b0;
  logic g_reset = 1'b1;
  logic g_clk_req;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] prev_exp;

  sme_aes_word_if #(.XLEN(XLEN), .SMAX(SMAX), .NLANE(NLANE), .RMAX(RMAX)) bus ();

  sme_aes_word #(
    .XLEN(XLEN), .SMAX(SMAX), .NLANE(NLANE), .SBOX_LAT(SBOX_LAT)
  ) dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .g_clk_req (g_clk_req),
    .bus       (bus)
  );

  always #5 g_clk = ~g_clk;

  typedef struct {
    logic [7:0]  ops;     // bit0 aeses .. bit7 aesdsmw
    logic [1:0]  bs;
    logic [3:0]  smectl;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] exp;
    int unsigned lat;
  } vec_t;

  vec_t vt [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] unmask(input logic [SMAX-1:0][XLEN-1:0] w);
    logic [31:0] r = '0;
    for (int s = 0; s < SMAX; s++) r = r ^ w[s];
    return r;
  endfunction

  function automatic int unsigned nsh_of(input logic [3:0] c);
    return (c == 4'd0 || c > 4'(SMAX)) ? SMAX : int'(c);
  endfunction

  task automatic shuffle_rng();
    for (int i = 0; i < NLANE * RMAX; i++) bus.rng[i] = $urandom();
  endtask

  task automatic drive_idle();
    bus.valid = 1'b0;
    bus.flush = 1'b0;
    bus.smectl_d = 4'd0;
    bus.bs = 2'd0;
    {bus.op_aesdsmw, bus.op_aesesmw, bus.op_isubw, bus.op_subw,
     bus.op_aesdsm, bus.op_aesds, bus.op_aesesm, bus.op_aeses} = 8'h00;
    bus.rs1 = '0;
    bus.rs2 = '0;
    shuffle_rng();
  endtask

  // Split rs1/rs2 into nsh random shares; shares >= nsh get garbage the DUT must drop.
  task automatic load(input vec_t v);
    int unsigned n = nsh_of(v.smectl);
    logic [31:0] a1 = v.rs1, a2 = v.rs2, r1, r2;
    for (int s = 0; s < SMAX; s++) begin
      r1 = $urandom();
      r2 = $urandom();
      if (s < int'(n) - 1) begin
        a1 = a1 ^ r1;
        a2 = a2 ^ r2;
      end else if (s == int'(n) - 1) begin
        r1 = a1;
        r2 = a2;
      end
      bus.rs1[s] = r1;
      bus.rs2[s] = r2;
    end
    bus.smectl_d = v.smectl;
    bus.bs = v.bs;
    {bus.op_aesdsmw, bus.op_aesesmw, bus.op_isubw, bus.op_subw,
     bus.op_aesdsm, bus.op_aesds, bus.op_aesesm, bus.op_aeses} = v.ops;
    shuffle_rng();
    bus.valid = 1'b1;
  endtask

  // Called at a negedge in an idle cycle (cycle 0); returns at a negedge in an idle cycle.
  task automatic run_vec(input string name, input vec_t v);
    int unsigned lat = 0;
    int unsigned n = nsh_of(v.smectl);
    logic [31:0] zor = '0;
    load(v);
    @(posedge g_clk);
    for (int c = 1; c < 40; c++) begin
      @(negedge g_clk);
      shuffle_rng();
      if (bus.ready === 1'b1) begin
        lat = c;
        break;
      end
    end
    check({name, "_latency"}, 32'(lat), 32'(v.lat));
    check({name, "_rd"}, unmask(bus.rd), v.exp);
    if (n < SMAX) begin
      for (int s = 0; s < SMAX; s++) if (s >= int'(n)) zor = zor | bus.rd[s];
      check({name, "_zero_shares"}, zor, 32'h0);
    end
    drive_idle();
    @(negedge g_clk);
    check({name, "_ready_strobe"}, {31'h0, bus.ready}, 32'h0);
  endtask

  initial begin
    logic rdy_seen;
    logic [31:0] zor;

    vt[0]  = '{8'h02, 2'd0, 4'd3, 32'h00000000, 32'h00000000, 32'ha56363c6, 4};
    vt[1]  = '{8'h40, 2'd0, 4'd3, 32'h00000000, 32'h6850829f, 32'hbca14d8e, 13};
    vt[2]  = '{8'h20, 2'd0, 4'd3, 32'h11111111, 32'h63636363, 32'h11111111, 13};
    vt[3]  = '{8'h10, 2'd0, 4'd3, 32'h00000000, 32'h53000000, 32'hed636363, 13};
    vt[4]  = '{8'h01, 2'd2, 4'd2, 32'h00000000, 32'h00530000, 32'h00ed0000, 4};
    vt[5]  = '{8'h01, 2'd2, 4'd0, 32'h00000000, 32'h00530000, 32'h00ed0000, 4};
    vt[6]  = '{8'h04, 2'd1, 4'd5, 32'h00000000, 32'h0000ed00, 32'h00005300, 4};
    vt[7]  = '{8'h08, 2'd0, 4'd3, 32'h01010101, 32'h0000007c, 32'h0a0c080f, 4};
    vt[8]  = '{8'h80, 2'd0, 4'd3, 32'h00000000, 32'h6532e319, 32'h455313db, 13};
    vt[9]  = '{8'hff, 2'd0, 4'd3, 32'h00000000, 32'h6532e319, 32'h455313db, 13};
    vt[10] = '{8'h01, 2'd3, 4'd1, 32'h00000000, 32'h53000000, 32'hed000000, 4};

    drive_idle();
    #12;
    check("reset_ready", {31'h0, bus.ready}, 32'h0);
    check("reset_rd", unmask(bus.rd) | bus.rd[0] | bus.rd[1], 32'h0);
    check("reset_clk_req", {31'h0, g_clk_req}, 32'h0);
    @(negedge g_clk);
    g_reset = 1'b0;
    @(negedge g_clk);

    for (int i = 0; i < 11; i++) begin
      run_vec($sformatf("vec%0d", i), vt[i]);
    end
    prev_exp = vt[10].exp;

    // No op bit set: must not be accepted.
    bus.valid = 1'b1;
    bus.rs2 = '1;
    rdy_seen = 1'b0;
    repeat (6) begin
      @(negedge g_clk);
      rdy_seen = rdy_seen | bus.ready;
    end
    check("noop_ready", {31'h0, rdy_seen}, 32'h0);
    drive_idle();
    @(negedge g_clk);
    check("noop_idle", {31'h0, g_clk_req}, 32'h0);
    check("noop_rd", unmask(bus.rd), prev_exp);

    // Flush in cycle 2 of a word op, then a new request accepted in cycle 3.
    load(vt[1]);
    @(posedge g_clk);
    rdy_seen = 1'b0;
    @(negedge g_clk);
    rdy_seen = rdy_seen | bus.ready;
    @(negedge g_clk);
    rdy_seen = rdy_seen | bus.ready;
    bus.flush = 1'b1;
    @(negedge g_clk);
    rdy_seen = rdy_seen | bus.ready;
    bus.flush = 1'b0;
    check("flush_ready", {31'h0, rdy_seen}, 32'h0);
    check("flush_rd_kept", unmask(bus.rd), prev_exp);
    run_vec("after_flush", vt[0]);

    // Asynchronous reset in the middle of a word op.
    load(vt[2]);
    @(posedge g_clk);
    repeat (4) @(negedge g_clk);
    #2 g_reset = 1'b1;
    #1;
    zor = '0;
    for (int s = 0; s < SMAX; s++) zor = zor | bus.rd[s];
    check("async_reset_ready", {31'h0, bus.ready}, 32'h0);
    check("async_reset_rd", zor, 32'h0);
    drive_idle();
    @(negedge g_clk);
    g_reset = 1'b0;
    @(negedge g_clk);
    run_vec("after_reset", vt[8]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
